// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state and lane helpers for the load/store unit.
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} lsu_state_e;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic       err;
  } lsu_req_t;

  // Byte-enable mask of the lanes touched; half uses addr[1] only, word ignores low bits.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << lo;
      SZ_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] mask_bits(input logic [3:0] m);
    mask_bits = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    misaligned = ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
  endfunction
endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: store merge into the old word and load extract/extend.
// Build option: none here (alignment-down falls out of ignoring the low address bits).
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] merged,
  output logic [31:0] loaded
);
  logic [31:0] rep, bm, shifted;
  logic [4:0]  sh;

  always_comb begin
    rep = wdata;
    sh  = 5'd0;
    case (size)
      SZ_BYTE: begin rep = {4{wdata[7:0]}};  sh = {lo, 3'b000};       end
      SZ_HALF: begin rep = {2{wdata[15:0]}}; sh = {lo[1], 4'b0000};   end
      default: begin rep = wdata;            sh = 5'd0;               end
    endcase
    bm      = mask_bits(lane_mask(size, lo));
    merged  = (old_word & ~bm) | (rep & bm);
    shifted = old_word >> sh;
    case (size)
      SZ_BYTE: loaded = {{24{~uns & shifted[7]}},  shifted[7:0]};
      SZ_HALF: loaded = {{16{~uns & shifted[15]}}, shifted[15:0]};
      default: loaded = old_word;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: byte/half/word requests to a word-only memory, RMW for sub-word stores.
// Build option: LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses error instead of aligning down.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4 * MEM_WORDS);

  lsu_state_e        state, state_nxt;
  lsu_req_t          req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, word_q, merged, loaded;
  logic              xfer, bad;

  assign xfer = req_valid & req_ready;

  always_comb begin
    bad = (req_size == SZ_ILL) || ({1'b0, req_addr} >= LIMIT);
`ifdef LSU_MISALIGN_TRAP_EN
    bad = bad || misaligned(req_size, req_addr[1:0]);
`else
    bad = bad;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (xfer) begin
        if (bad)                     state_nxt = ST_DONE;
        else if (!req_we)            state_nxt = ST_RD;
        else if (req_size == SZ_WORD) state_nxt = ST_WR;
        else                         state_nxt = ST_RD;
      end
      ST_RD:   state_nxt = req_q.we ? ST_WR : ST_DONE;
      ST_WR:   state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Everything memory-facing is decoded from state so reset drops mem_we at once.
  always_comb begin
    req_ready  = (state == ST_IDLE);
    mem_we     = (state == ST_WR);
    mem_a      = '0;
    mem_wd     = '0;
    resp_valid = (state == ST_DONE);
    resp_err   = (state == ST_DONE) && req_q.err;
    resp_rdata = '0;
    if (state == ST_RD || state == ST_WR) mem_a = {addr_q[ADDR_W-1:2], 2'b00};
    if (state == ST_WR) mem_wd = merged;
    if (state == ST_DONE && !req_q.err && !req_q.we) resp_rdata = loaded;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      if (xfer) begin
        req_q   <= '{we: req_we, size: req_size, uns: req_unsigned, err: bad};
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == ST_RD) word_q <= mem_rd;
    end
  end

  // Word stores take wdata straight through: a full mask makes old_word irrelevant.
  lsu_lane u_lane (
    .old_word(word_q),
    .wdata   (wdata_q),
    .lo      (addr_q[1:0]),
    .size    (req_q.size),
    .uns     (req_q.uns),
    .merged  (merged),
    .loaded  (loaded)
  );
endmodule
